weight_tile_buffer: RTL
=======================

Name: weight_tile_buffer

Overview:
- On-chip weight store and the responder side of the weight fetch interface issued by the weight controller.
- Off-chip logic fills 6x6 weight tiles one element per cycle through a load port.
- The read port takes a tile address plus a request strobe and returns the addressed tile and the next tile (addr, addr+1) one cycle later with a valid flag.
- Sits between the off-chip weight loader and the weight controller feeding the PE arrays.

Parameters:
- DEPTH, 64, number of 6x6 tiles stored.
- ADDR_W, 12, tile address width; must satisfy 2^ADDR_W >= DEPTH.
- DATA_W, 12, signed weight element width.
- TILE, 6, tile edge; fixed at 6, other values unsupported.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- weight_addr_i  in  ADDR_W  tile address of the first tile of the read pair.
- weight_req_i  in  1  read request strobe.
- weight_data_o_1  out  signed DATA_W [5:0][5:0]  tile at weight_addr_i.
- weight_data_o_2  out  signed DATA_W [5:0][5:0]  tile at weight_addr_i+1.
- weight_valid_o  out  1  response valid, one-cycle pulse.
- weight_err_o  out  1  address out of range, pulses with weight_valid_o.
- load_start_i  in  1  begin tile load.
- load_tile_i  in  ADDR_W  destination tile, sampled with load_start_i.
- load_data_i  in  signed DATA_W  element, row-major: element k maps to [k/6][k%6].
- load_valid_i  in  1  load_data_i valid.
- load_ready_o  out  1  high in LOAD state.
- load_done_o  out  1  one-cycle pulse when the tile is committed.

Behaviour:
- Reset, asynchronous: all outputs 0; storage array and staging tile cleared to 0; FSM to IDLE; element counter 0.
- Read path:
  - weight_req_i sampled at edge N; data, valid and err registered, visible after edge N, so latency is 1 cycle.
  - Back-to-back requests every cycle are accepted.
  - Without a request, weight_valid_o=0 and the data outputs hold their last value.
- Address range:
  - addr <= DEPTH-2: both tiles returned, err=0.
  - addr == DEPTH-1: tile_1 returned, tile_2 all zero, err=1.
  - addr >= DEPTH: both tiles zero, err=1.
  - No wrap-around.
- Load FSM states: IDLE, LOAD, COMMIT.
  - IDLE: load_start_i -> LOAD; latch load_tile_i; counter=0.
  - LOAD: each load_valid_i writes the staging element at the counter and increments it.
  - LOAD: the element at counter 35 -> COMMIT.
  - LOAD: load_valid_i=0 stalls indefinitely.
  - COMMIT: staging tile written to storage[tile]; load_done_o=1 for this cycle; -> IDLE.
  - COMMIT lasts exactly one cycle; load_ready_o=0.
- Abort: load_start_i in LOAD restarts with the new load_tile_i and counter=0; the old partial tile is discarded, storage untouched, no done pulse.
- Same-cycle load_start_i and load_valid_i in LOAD: start wins, data ignored.
- load_start_i in COMMIT: ignored.
- load_tile_i >= DEPTH: the load runs and the commit is dropped; done still pulses.
- Read/commit collision: when a read addresses a tile in the same cycle it commits, the read returns the old content (read-before-write).
- Reads of a tile mid-load return the old committed content; storage changes only in COMMIT.
- Reset during LOAD: partial tile lost; no done pulse.
- Address arithmetic addr+1 is computed at ADDR_W+1 bits so no overflow is possible.

Optional Feature:
- WEIGHT_BUF_FWD_EN defined: a read colliding with a same-cycle commit returns the newly committed staging tile for tile_1 and/or tile_2, whichever matches.
- Undefined: read-before-write as specified above.

Decomposition:
- Shared package wino_weight_pkg:
  - TILE=6 constant.
  - weight_t, a signed 12-bit typedef.
  - weight_tile_t, a [5:0][5:0] array of weight_t.
  - load FSM state enum (IDLE, LOAD, COMMIT).
- One natural sub-module: weight_tile_loader. It holds the FSM, counter and staging tile, and outputs commit_en, commit_tile and commit_data to the storage/read logic in the top.

Test Plan:
- Load tile 3 with elements k=0..35 valued k-18, then req addr=3 -> next cycle valid=1, err=0, tile_1[0][0]=-18, [5][5]=17, tile_2 = tile 4 content (0 after reset).
- Load tiles 10 and 11 with constants 5 and -7, req addr=10 on 3 consecutive cycles -> 3 consecutive valid pulses, tile_1 all 5, tile_2 all -7.
- req addr=63 (DEPTH=64) -> tile_1 = tile 63, tile_2 zero, err=1; req addr=100 -> both zero, err=1.
- Start load tile 2, 20 elements of value 9, then load_start_i tile 2 again with 36 elements of value 1 -> single done pulse, tile 2 all 1, no 9s.
- Load tile 5 with value 4, then reload it with value 8 while req addr=5 in the COMMIT cycle -> response all 4 (all 8 with WEIGHT_BUF_FWD_EN); the next req returns all 8.
- Assert reset after 10 elements of a tile 7 load -> outputs 0, no done pulse, load_ready_o=0; req addr=7 returns zeros.

Source files
------------

// File: rtl/wino_weight_pkg.sv
// Shared types for the Winograd weight path: tile geometry, element and tile
// types, and the tile-load FSM state encoding.
package wino_weight_pkg;

  localparam int TILE       = 6;
  localparam int TILE_ELEMS = TILE * TILE;
  localparam int CNT_W      = 6;

  typedef logic signed [11:0] weight_t;
  typedef weight_t [TILE-1:0][TILE-1:0] weight_tile_t;

  typedef enum logic [1:0] {
    LD_IDLE   = 2'd0,
    LD_LOAD   = 2'd1,
    LD_COMMIT = 2'd2
  } load_state_t;

endpackage

// File: rtl/weight_tile_loader.sv
// Tile loader: collects 36 row-major elements into a staging tile, then
// presents the finished tile for a single commit cycle. A start while loading
// throws away the partial tile and begins again at element 0.
// Handshake: an element is taken on each edge where state_o == LD_LOAD and
// load_valid_i is high (load_start_i has priority); no valid means the loader
// waits for as long as needed.
module weight_tile_loader
  import wino_weight_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_start_i,
  input  logic [ADDR_W-1:0]        load_tile_i,
  input  logic signed [DATA_W-1:0] load_data_i,
  input  logic                     load_valid_i,
  output logic                     commit_en,
  output logic [ADDR_W-1:0]        commit_tile,
  output weight_tile_t             commit_data,
  output load_state_t              state_o
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TILE_ELEMS - 1);

  load_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [ADDR_W-1:0] tile_q;
  weight_tile_t     staging_q;
  logic [2:0]       ld_row, ld_col;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= LD_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and decoded outputs; start restarts, start in COMMIT is ignored.
  always_comb begin
    state_d   = state_q;
    commit_en = 1'b0;
    ld_row    = 3'(cnt_q / CNT_W'(TILE));
    ld_col    = 3'(cnt_q % CNT_W'(TILE));
    case (state_q)
      LD_IDLE:   if (load_start_i) state_d = LD_LOAD;
      LD_LOAD: begin
        if (load_start_i)                             state_d = LD_LOAD;
        else if (load_valid_i && (cnt_q == LAST_IDX)) state_d = LD_COMMIT;
      end
      LD_COMMIT: begin
        commit_en = 1'b1;
        state_d   = LD_IDLE;
      end
      default:   state_d = LD_IDLE;
    endcase
  end

  // Destination latch, element counter and staging tile writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tile_q    <= '0;
      cnt_q     <= '0;
      staging_q <= '0;
    end else if (load_start_i && (state_q != LD_COMMIT)) begin
      tile_q <= load_tile_i;
      cnt_q  <= '0;
    end else if ((state_q == LD_LOAD) && load_valid_i) begin
      staging_q[ld_row][ld_col] <= load_data_i;
      cnt_q                     <= cnt_q + 1'b1;
    end
  end

  assign commit_tile = tile_q;
  assign commit_data = staging_q;
  assign state_o     = state_q;

endmodule

// File: rtl/weight_tile_buffer.sv
// Weight tile store: loader-fed storage of DEPTH 6x6 tiles with a one-cycle
// paired read (addr, addr+1) for the weight controller.
// Optional macro WEIGHT_BUF_FWD_EN: a read that hits the tile being committed
// in the same cycle returns the new staging tile instead of the old content.
module weight_tile_buffer
  import wino_weight_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 12,
  parameter int TILE   = 6
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [ADDR_W-1:0]                           weight_addr_i,
  input  logic                                        weight_req_i,
  output logic signed [TILE-1:0][TILE-1:0][DATA_W-1:0] weight_data_o_1,
  output logic signed [TILE-1:0][TILE-1:0][DATA_W-1:0] weight_data_o_2,
  output logic                                        weight_valid_o,
  output logic                                        weight_err_o,
  input  logic                                        load_start_i,
  input  logic [ADDR_W-1:0]                           load_tile_i,
  input  logic signed [DATA_W-1:0]                    load_data_i,
  input  logic                                        load_valid_i,
  output logic                                        load_ready_o,
  output logic                                        load_done_o
);

  localparam int              IDX_W   = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  weight_tile_t      mem [DEPTH];
  logic              commit_en;
  logic [ADDR_W-1:0] commit_tile;
  weight_tile_t      commit_data;
  load_state_t       load_state;
  logic [ADDR_W:0]   commit_x, addr_1, addr_2;
  logic              in_1, in_2, wr_en;
  weight_tile_t      rd_tile_1, rd_tile_2;

  weight_tile_loader #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_loader (
    .clk          (clk),
    .reset        (reset),
    .load_start_i (load_start_i),
    .load_tile_i  (load_tile_i),
    .load_data_i  (load_data_i),
    .load_valid_i (load_valid_i),
    .commit_en    (commit_en),
    .commit_tile  (commit_tile),
    .commit_data  (commit_data),
    .state_o      (load_state)
  );

  assign load_ready_o = (load_state == LD_LOAD);
  assign load_done_o  = (load_state == LD_COMMIT);

  // Read address decode at ADDR_W+1 bits so addr+1 never wraps; out-of-range tiles read as zero.
  always_comb begin
    commit_x  = {1'b0, commit_tile};
    addr_1    = {1'b0, weight_addr_i};
    addr_2    = addr_1 + (ADDR_W+1)'(1);
    in_1      = (addr_1 < DEPTH_X);
    in_2      = (addr_2 < DEPTH_X);
    wr_en     = commit_en && (commit_x < DEPTH_X);
    rd_tile_1 = '0;
    rd_tile_2 = '0;
    if (in_1) rd_tile_1 = mem[addr_1[IDX_W-1:0]];
    if (in_2) rd_tile_2 = mem[addr_2[IDX_W-1:0]];
`ifdef WEIGHT_BUF_FWD_EN
    if (wr_en && in_1 && (commit_x == addr_1)) rd_tile_1 = commit_data;
    if (wr_en && in_2 && (commit_x == addr_2)) rd_tile_2 = commit_data;
`endif
  end

  // Tile storage; only a commit to an in-range tile changes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[commit_x[IDX_W-1:0]] <= commit_data;
    end
  end

  // Registered read response; data holds when there is no request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      weight_data_o_1 <= '0;
      weight_data_o_2 <= '0;
      weight_valid_o  <= 1'b0;
      weight_err_o    <= 1'b0;
    end else if (weight_req_i) begin
      weight_data_o_1 <= rd_tile_1;
      weight_data_o_2 <= rd_tile_2;
      weight_valid_o  <= 1'b1;
      weight_err_o    <= !in_2;
    end else begin
      weight_valid_o  <= 1'b0;
      weight_err_o    <= 1'b0;
    end
  end

endmodule
